best_report_tx: RTL

- Downstream of the best-hash tracker. Periodically, or on request, snapshots the current best nonce and bits-off score.
- In the same cycle it pulses the tracker's clear input, so the tracker starts a fresh search window.
- Serialises the snapshot as a 36-byte checksummed frame over a valid/ready byte stream that feeds the UART transmitter.

---
 rtl/best_report_tx_pkg.sv | 22 ++
 rtl/best_report_tx_byte_sel.sv | 45 ++++
 rtl/best_report_tx.sv | 112 +++++++++++
 3 files changed

// File: rtl/best_report_tx_pkg.sv
// Shared constants for the best-hash report transmitter.
// Frame layout (36 bytes): sync, bits-off (16-bit, big-endian), nonce (MSB first), checksum.
package best_report_tx_pkg;

  localparam logic [7:0]  FRAME_SYNC = 8'hA5;
  localparam int unsigned FRAME_LEN  = 36;

  // Byte offsets within the frame
  localparam logic [5:0] BITS_OFS  = 6'd1;
  localparam logic [5:0] NONCE_OFS = 6'd3;
  localparam logic [5:0] CSUM_OFS  = 6'd35;

  // FSM state encoding
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_SEND = 1'b1;

  // True for the bytes that feed the running XOR (bits-off and nonce bytes)
  function automatic logic csum_covers(input logic [5:0] idx);
    return (idx >= BITS_OFS) && (idx < CSUM_OFS);
  endfunction

endpackage

// File: rtl/best_report_tx_byte_sel.sv
// report_byte_sel: maps the frozen snapshot plus a byte index to the frame byte.
// Ports:
//   snap_nonce_i  snapshot nonce
//   snap_bits_i   snapshot bits-off score
//   csum_i        running checksum (valid when idx_i is the checksum slot)
//   idx_i         byte index 0..35
//   byte_o        selected frame byte
module report_byte_sel
  import best_report_tx_pkg::*;
#(
  parameter int unsigned NONCE_W = 256,
  parameter int unsigned BITS_W  = 10
) (
  input  logic [NONCE_W-1:0] snap_nonce_i,
  input  logic [BITS_W-1:0]  snap_bits_i,
  input  logic [7:0]         csum_i,
  input  logic [5:0]         idx_i,
  output logic [7:0]         byte_o
);

  logic [15:0]        w_bits16;
  logic [5:0]         w_nidx;
  logic [NONCE_W-1:0] w_nonce_sh;

  assign w_bits16 = 16'(snap_bits_i);
  assign w_nidx   = idx_i - NONCE_OFS;
  // Shift the wanted nonce byte into the top lane so MSB-first needs no reversal
  assign w_nonce_sh = snap_nonce_i << {w_nidx, 3'b000};

  always_comb begin
    byte_o = 8'h00;
    if (idx_i == 6'd0) begin
      byte_o = FRAME_SYNC;
    end else if (idx_i == BITS_OFS) begin
      byte_o = w_bits16[15:8];
    end else if (idx_i == BITS_OFS + 6'd1) begin
      byte_o = w_bits16[7:0];
    end else if (idx_i == CSUM_OFS) begin
      byte_o = csum_i;
    end else if (idx_i >= NONCE_OFS && idx_i < CSUM_OFS) begin
      byte_o = w_nonce_sh[NONCE_W-1 -: 8];
    end
  end

endmodule

// File: rtl/best_report_tx.sv
// best_report_tx: periodically (or on request) snapshots the best nonce/score from the
// tracker, pulses the tracker clear in the same cycle, and streams a 36-byte
// checksummed frame over a valid/ready byte interface.
// Ports:
//   clk_i, reset_i     clock, synchronous active-high reset
//   best_nonce_i       best nonce from the tracker
//   best_bits_off_i    best score; all-ones means no hash seen yet
//   report_req_i       one-cycle request for an immediate report
//   tx_data_o/valid_o  byte stream towards the UART transmitter
//   tx_ready_i         transmitter accepts the byte
//   clear_best_o       one-cycle clear to the tracker
//   busy_o             frame in progress
module best_report_tx
  import best_report_tx_pkg::*;
#(
  parameter int unsigned REPORT_INTERVAL = 50_000_000,
  parameter int unsigned NONCE_W         = 256,
  parameter int unsigned BITS_W          = 10
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NONCE_W-1:0] best_nonce_i,
  input  logic [BITS_W-1:0]  best_bits_off_i,
  input  logic               report_req_i,
  output logic [7:0]         tx_data_o,
  output logic               tx_valid_o,
  input  logic               tx_ready_i,
  output logic               clear_best_o,
  output logic               busy_o
);

  localparam int unsigned CNT_W = (REPORT_INTERVAL > 2) ? $clog2(REPORT_INTERVAL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REPORT_INTERVAL - 1);

  logic               r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [5:0]         r_idx;
  logic [7:0]         r_csum;
  logic [NONCE_W-1:0] r_snap_nonce;
  logic [BITS_W-1:0]  r_snap_bits;

  logic       w_idle;
  logic       w_expire;
  logic       w_trig;
  logic       w_xfer;
  logic [7:0] w_byte;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_expire = (r_cnt == CNT_LAST);
  // An all-ones score means the tracker has nothing to report in this window
  assign w_trig   = w_idle && (w_expire || report_req_i) && !(&best_bits_off_i);
  assign w_xfer   = tx_valid_o && tx_ready_i;

  assign clear_best_o = w_trig;
  assign tx_valid_o   = (r_state == ST_SEND);
  assign busy_o       = (r_state == ST_SEND);
  assign tx_data_o    = tx_valid_o ? w_byte : 8'h00;

  report_byte_sel #(
    .NONCE_W (NONCE_W),
    .BITS_W  (BITS_W)
  ) u_byte_sel (
    .snap_nonce_i (r_snap_nonce),
    .snap_bits_i  (r_snap_bits),
    .csum_i       (r_csum),
    .idx_i        (r_idx),
    .byte_o       (w_byte)
  );

  // Snapshot is datapath only; it is never observed outside SEND, so no reset
  always_ff @(posedge clk_i) begin
    if (w_trig) begin
      r_snap_nonce <= best_nonce_i;
      r_snap_bits  <= best_bits_off_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_csum  <= '0;
    end else if (r_state == ST_IDLE) begin
      if (w_trig) begin
        r_state <= ST_SEND;
        r_cnt   <= '0;
        r_idx   <= '0;
        r_csum  <= '0;
      end else if (w_expire) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      // SEND: counter frozen, requests ignored
      if (w_xfer) begin
        if (csum_covers(r_idx)) begin
          r_csum <= r_csum ^ w_byte;
        end
        if (r_idx == CSUM_OFS) begin
          r_state <= ST_IDLE;
          r_idx   <= '0;
          r_cnt   <= '0;
        end else begin
          r_idx <= r_idx + 6'd1;
        end
      end
    end
  end

endmodule
